rename_regfile: RTL and testbench

//  Architectural register file with per-register rename tags. Sits beside the ROB.

---
 rtl/rename_regfile_pkg.sv | 10 +
 rtl/rename_regfile_rf_read_port.sv | 35 +++
 rtl/rename_regfile.sv | 91 +++++++++
 tb/tb_rename_regfile.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_regfile_pkg.sv
// Shared sizing for the rename register file: data width, register count, ROB tag width.
package rename_regfile_pkg;
  localparam int RR_XLEN  = 32;
  localparam int RR_NREG  = 32;
  localparam int RR_TAG_W = 4;
  localparam int RR_RIDX_W = $clog2(RR_NREG);

  typedef logic [RR_RIDX_W-1:0] ridx_t;
  typedef logic [RR_TAG_W-1:0]  rbid_t;
endpackage

// File: rtl/rename_regfile_rf_read_port.sv
// One operand read port: x0 / commit-bypass / committed value / producer tag priority mux.
module rename_regfile_rf_read_port
  import rename_regfile_pkg::*;
#(
  parameter int XLEN   = RR_XLEN,
  parameter int TAG_W  = RR_TAG_W,
  parameter int RIDX_W = RR_RIDX_W
) (
  input  logic [RIDX_W-1:0] addr,
  input  logic              cm_valid,
  input  logic [RIDX_W-1:0] cm_rd,
  input  logic [TAG_W-1:0]  cm_tag,
  input  logic [XLEN-1:0]   cm_val,
  input  logic              reg_busy,
  input  logic [TAG_W-1:0]  reg_tag,
  input  logic [XLEN-1:0]   reg_val,
  output logic              ready,
  output logic [XLEN-1:0]   val
);
  always_comb begin
    ready = 1'b1;
    val   = '0;
    if (addr == '0) begin
      ready = 1'b1;
      val   = '0;
    end else if (cm_valid && cm_rd == addr && reg_busy && reg_tag == cm_tag) begin
      val = cm_val;
    end else if (!reg_busy) begin
      val = reg_val;
    end else begin
      ready = 1'b0;
      val   = {{(XLEN-TAG_W){1'b0}}, reg_tag};
    end
  end
endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register ROB rename tags; two combinational
// operand reads, one rename and one commit per cycle.
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int XLEN  = RR_XLEN,
  parameter int NREG  = RR_NREG,
  parameter int TAG_W = RR_TAG_W,
  localparam int RIDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              rn_valid,
  input  logic [RIDX_W-1:0] rn_rd,
  input  logic [TAG_W-1:0]  rn_tag,
  input  logic              cm_valid,
  input  logic [RIDX_W-1:0] cm_rd,
  input  logic [TAG_W-1:0]  cm_tag,
  input  logic [XLEN-1:0]   cm_val,
  input  logic [RIDX_W-1:0] rs1_addr,
  output logic              rs1_ready,
  output logic [XLEN-1:0]   rs1_val,
  input  logic [RIDX_W-1:0] rs2_addr,
  output logic              rs2_ready,
  output logic [XLEN-1:0]   rs2_val
);
  logic [NREG-1:0][XLEN-1:0]  val_q, val_d;
  logic [NREG-1:0]            busy_q, busy_d;
  logic [NREG-1:0][TAG_W-1:0] tag_q, tag_d;

  // Commit is older than both flush and rename, so its value write always lands;
  // flush then wipes mappings, otherwise a same-rd rename overrides the commit's busy clear.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy) begin
      if (cm_valid && cm_rd != '0) begin
        val_d[cm_rd] = cm_val;
        if (tag_q[cm_rd] == cm_tag) busy_d[cm_rd] = 1'b0;
      end
      if (flush) begin
        busy_d = '0;
        tag_d  = '0;
      end else if (rn_valid && rn_rd != '0) begin
        busy_d[rn_rd] = 1'b1;
        tag_d[rn_rd]  = rn_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  rename_regfile_rf_read_port #(.XLEN(XLEN), .TAG_W(TAG_W), .RIDX_W(RIDX_W)) u_rd1 (
    .addr     (rs1_addr),
    .cm_valid (cm_valid),
    .cm_rd    (cm_rd),
    .cm_tag   (cm_tag),
    .cm_val   (cm_val),
    .reg_busy (busy_q[rs1_addr]),
    .reg_tag  (tag_q[rs1_addr]),
    .reg_val  (val_q[rs1_addr]),
    .ready    (rs1_ready),
    .val      (rs1_val)
  );

  rename_regfile_rf_read_port #(.XLEN(XLEN), .TAG_W(TAG_W), .RIDX_W(RIDX_W)) u_rd2 (
    .addr     (rs2_addr),
    .cm_valid (cm_valid),
    .cm_rd    (cm_rd),
    .cm_tag   (cm_tag),
    .cm_val   (cm_val),
    .reg_busy (busy_q[rs2_addr]),
    .reg_tag  (tag_q[rs2_addr]),
    .reg_val  (val_q[rs2_addr]),
    .ready    (rs2_ready),
    .val      (rs2_val)
  );
endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: directed scenarios plus randomized traffic against a
// register-level behavioural model.
module tb_rename_regfile;
  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        rn_valid, cm_valid;
  logic [4:0]  rn_rd, cm_rd, rs1_addr, rs2_addr;
  logic [3:0]  rn_tag, cm_tag;
  logic [31:0] cm_val, rs1_val, rs2_val;
  logic        rs1_ready, rs2_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];

  rename_regfile dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .rn_valid(rn_valid), .rn_rd(rn_rd), .rn_tag(rn_tag),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
    .rs1_addr(rs1_addr), .rs1_ready(rs1_ready), .rs1_val(rs1_val),
    .rs2_addr(rs2_addr), .rs2_ready(rs2_ready), .rs2_val(rs2_val)
  );

  always #5 clk = ~clk;

  function automatic void model_read(input int a, output logic r, output logic [31:0] v);
    if (a == 0) begin r = 1'b1; v = 32'h0; end
    else if (cm_valid && int'(cm_rd) == a && m_busy[a] && m_tag[a] == cm_tag) begin
      r = 1'b1; v = cm_val;
    end else if (!m_busy[a]) begin r = 1'b1; v = m_val[a]; end
    else begin r = 1'b0; v = {28'h0, m_tag[a]}; end
  endfunction

  // Applies the architectural effect of the current inputs at the coming edge.
  task automatic model_update();
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0; end
    end else if (rdy) begin
      bit tag_match;
      tag_match = (cm_valid && cm_rd != 0) && (m_tag[cm_rd] == cm_tag);
      if (cm_valid && cm_rd != 0) m_val[cm_rd] = cm_val;
      if (tag_match) m_busy[cm_rd] = 0;
      if (flush) begin
        for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = '0; end
      end else if (rn_valid && rn_rd != 0) begin
        m_busy[rn_rd] = 1; m_tag[rn_rd] = rn_tag;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    rn_valid = 1'b0; rn_rd = '0; rn_tag = '0;
    cm_valid = 1'b0; cm_rd = '0; cm_tag = '0; cm_val = '0;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b0; tick(); idle();
    rs1_addr = 5; rs2_addr = 31; #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h0) begin
      errors++; $display("FAIL reset_x5 got ready=%0b val=%h want ready=1 val=0", rs1_ready, rs1_val);
    end
    checks++;
    if (rs2_ready !== 1'b1 || rs2_val !== 32'h0) begin
      errors++; $display("FAIL reset_x31 got ready=%0b val=%h want ready=1 val=0", rs2_ready, rs2_val);
    end
    cm_valid = 1'b1; cm_rd = 0; cm_val = 32'hFFFF; rs1_addr = 0; #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h0) begin
      errors++; $display("FAIL x0_bypass got ready=%0b val=%h want ready=1 val=0", rs1_ready, rs1_val);
    end
    tick(); idle(); #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h0) begin
      errors++; $display("FAIL x0_write got ready=%0b val=%h want ready=1 val=0", rs1_ready, rs1_val);
    end
  endtask

  task automatic test_rename_commit();
    rn_valid = 1'b1; rn_rd = 3; rn_tag = 7; tick(); idle();
    rs1_addr = 3; #1;
    checks++;
    if (rs1_ready !== 1'b0 || rs1_val !== 32'h7) begin
      errors++; $display("FAIL rename_x3 got ready=%0b val=%h want ready=0 val=7", rs1_ready, rs1_val);
    end
    cm_valid = 1'b1; cm_rd = 3; cm_tag = 7; cm_val = 32'h1234; #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h1234) begin
      errors++; $display("FAIL bypass_x3 got ready=%0b val=%h want ready=1 val=1234", rs1_ready, rs1_val);
    end
    tick(); idle(); #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h1234) begin
      errors++; $display("FAIL commit_x3 got ready=%0b val=%h want ready=1 val=1234", rs1_ready, rs1_val);
    end
  endtask

  task automatic test_stale_commit();
    rn_valid = 1'b1; rn_rd = 4; rn_tag = 2; tick();
    rn_tag = 9; tick(); idle();
    rs2_addr = 4; cm_valid = 1'b1; cm_rd = 4; cm_tag = 2; cm_val = 32'hAA; #1;
    checks++;
    if (rs2_ready !== 1'b0 || rs2_val !== 32'h9) begin
      errors++; $display("FAIL stale_bypass got ready=%0b val=%h want ready=0 val=9", rs2_ready, rs2_val);
    end
    tick(); idle(); #1;
    checks++;
    if (rs2_ready !== 1'b0 || rs2_val !== 32'h9) begin
      errors++; $display("FAIL stale_commit got ready=%0b val=%h want ready=0 val=9", rs2_ready, rs2_val);
    end
    cm_valid = 1'b1; cm_rd = 4; cm_tag = 9; cm_val = 32'hBB; #1;
    checks++;
    if (rs2_ready !== 1'b1 || rs2_val !== 32'hBB) begin
      errors++; $display("FAIL young_bypass got ready=%0b val=%h want ready=1 val=bb", rs2_ready, rs2_val);
    end
    tick(); idle(); #1;
    checks++;
    if (rs2_ready !== 1'b1 || rs2_val !== 32'hBB) begin
      errors++; $display("FAIL young_commit got ready=%0b val=%h want ready=1 val=bb", rs2_ready, rs2_val);
    end
  endtask

  task automatic test_same_rd();
    cm_valid = 1'b1; cm_rd = 6; cm_tag = 1; cm_val = 32'h5;
    rn_valid = 1'b1; rn_rd = 6; rn_tag = 3; tick(); idle();
    rs1_addr = 6; #1;
    checks++;
    if (rs1_ready !== 1'b0 || rs1_val !== 32'h3) begin
      errors++; $display("FAIL same_rd_tag got ready=%0b val=%h want ready=0 val=3", rs1_ready, rs1_val);
    end
    flush = 1'b1; tick(); idle(); #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h5) begin
      errors++; $display("FAIL same_rd_val got ready=%0b val=%h want ready=1 val=5", rs1_ready, rs1_val);
    end
  endtask

  task automatic test_flush();
    rn_valid = 1'b1; rn_rd = 1; rn_tag = 4; tick();
    rn_rd = 2; rn_tag = 5; tick(); idle();
    flush = 1'b1; cm_valid = 1'b1; cm_rd = 8; cm_tag = 0; cm_val = 32'h77;
    rn_valid = 1'b1; rn_rd = 9; rn_tag = 6; tick(); idle();
    rs1_addr = 1; rs2_addr = 2; #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h0) begin
      errors++; $display("FAIL flush_x1 got ready=%0b val=%h want ready=1 val=0", rs1_ready, rs1_val);
    end
    checks++;
    if (rs2_ready !== 1'b1 || rs2_val !== 32'h0) begin
      errors++; $display("FAIL flush_x2 got ready=%0b val=%h want ready=1 val=0", rs2_ready, rs2_val);
    end
    rs1_addr = 8; rs2_addr = 9; #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h77) begin
      errors++; $display("FAIL flush_x8 got ready=%0b val=%h want ready=1 val=77", rs1_ready, rs1_val);
    end
    checks++;
    if (rs2_ready !== 1'b1 || rs2_val !== 32'h0) begin
      errors++; $display("FAIL flush_x9 got ready=%0b val=%h want ready=1 val=0", rs2_ready, rs2_val);
    end
  endtask

  task automatic test_hold_and_reset();
    rdy = 1'b0; rn_valid = 1'b1; rn_rd = 10; rn_tag = 3;
    cm_valid = 1'b1; cm_rd = 8; cm_tag = 0; cm_val = 32'h99; flush = 1'b0;
    tick(); idle();
    rs1_addr = 10; rs2_addr = 8; #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h0) begin
      errors++; $display("FAIL hold_x10 got ready=%0b val=%h want ready=1 val=0", rs1_ready, rs1_val);
    end
    checks++;
    if (rs2_ready !== 1'b1 || rs2_val !== 32'h77) begin
      errors++; $display("FAIL hold_x8 got ready=%0b val=%h want ready=1 val=77", rs2_ready, rs2_val);
    end
    rn_valid = 1'b1; rn_rd = 11; rn_tag = 5; tick(); idle();
    rst = 1'b0; rn_valid = 1'b1; rn_rd = 12; rn_tag = 1; tick(); idle();
    rs1_addr = 11; rs2_addr = 8; #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h0) begin
      errors++; $display("FAIL rst_x11 got ready=%0b val=%h want ready=1 val=0", rs1_ready, rs1_val);
    end
    checks++;
    if (rs2_ready !== 1'b1 || rs2_val !== 32'h0) begin
      errors++; $display("FAIL rst_x8 got ready=%0b val=%h want ready=1 val=0", rs2_ready, rs2_val);
    end
  endtask

  task automatic test_random();
    logic        er;
    logic [31:0] ev;
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 99) != 0);
      rdy      = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      rn_valid = $urandom_range(0, 1);
      rn_rd    = 5'($urandom_range(0, 7));
      rn_tag   = 4'($urandom);
      cm_valid = $urandom_range(0, 1);
      cm_rd    = 5'($urandom_range(0, 7));
      cm_tag   = ($urandom_range(0, 1) != 0) ? m_tag[cm_rd] : 4'($urandom);
      cm_val   = $urandom;
      rs1_addr = ($urandom_range(0, 2) == 0) ? cm_rd : 5'($urandom_range(0, 9));
      rs2_addr = 5'($urandom_range(0, 31));
      #1;
      model_read(int'(rs1_addr), er, ev);
      checks++;
      if (rs1_ready !== er || rs1_val !== ev) begin
        errors++;
        $display("FAIL rand_rs1 cyc=%0d x%0d got ready=%0b val=%h want ready=%0b val=%h",
                 c, rs1_addr, rs1_ready, rs1_val, er, ev);
      end
      model_read(int'(rs2_addr), er, ev);
      checks++;
      if (rs2_ready !== er || rs2_val !== ev) begin
        errors++;
        $display("FAIL rand_rs2 cyc=%0d x%0d got ready=%0b val=%h want ready=%0b val=%h",
                 c, rs2_addr, rs2_ready, rs2_val, er, ev);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0; end
    idle(); rs1_addr = '0; rs2_addr = '0;
    #2;
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_same_rd();
    test_flush();
    test_hold_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
